// File: rtl/ro_freq_counter.sv
// rtl/ro_freq_counter.sv - gated rising-edge counter for a ring-oscillator tap
//
// Ports:
//   wb_clk_i    in   system clock, the only clock in the block
//   wb_rst_i    in   synchronous active-high reset
//   ro_in       in   ring-oscillator output, asynchronous to wb_clk_i
//   start_i     in   one-cycle measurement request (honoured in IDLE or DONE)
//   gate_sel_i  in   window select, W = 2^(GATE_LOG2 + 2*sel), latched on start
//   ack_i       in   releases a held result (DONE -> IDLE)
//   busy_o      out  measurement in progress (ARM or COUNT)
//   done_o      out  result held (DONE)
//   count_o     out  rising-edge count of the last completed measurement
//   ovf_o       out  edge counter saturated during the last measurement
module ro_freq_counter #(
  parameter int CNT_W       = 16,
  parameter int GATE_LOG2   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             ro_in,
  input  logic             start_i,
  input  logic [1:0]       gate_sel_i,
  input  logic             ack_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] count_o,
  output logic             ovf_o
);

  // Sized for sel=3 so W-1 always fits without wrapping.
  localparam int WIN_W = GATE_LOG2 + 7;
  localparam int ARM_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   accept;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise;

  logic [1:0]       gate_sel_q;
  logic [ARM_W-1:0] arm_cnt;
  logic [WIN_W-1:0] win_cnt;
  logic [WIN_W-1:0] win_load;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] edge_nxt;
  logic             ovf_acc;
  logic             ovf_nxt;

  // Synchronizer chain plus one history flop for edge detection.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ro_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

  always_comb begin
    win_load = (WIN_W'(1) << (GATE_LOG2 + 2 * int'(gate_sel_q))) - WIN_W'(1);
  end

  // Saturating increment; ovf records an edge that arrived while already at max.
  always_comb begin
    edge_nxt = edge_cnt;
    ovf_nxt  = ovf_acc;
    if (rise) begin
      if (edge_cnt == {CNT_W{1'b1}}) begin
        ovf_nxt = 1'b1;
      end else begin
        edge_nxt = edge_cnt + CNT_W'(1);
      end
    end
  end

  // State register; busy/done are flopped from the next state so they are
  // pure register outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_o  <= (state_d == S_ARM) || (state_d == S_COUNT);
      done_o  <= (state_d == S_DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_ARM;
          accept  = 1'b1;
        end
      end
      S_ARM: begin
        if (arm_cnt == '0) state_d = S_COUNT;
      end
      S_COUNT: begin
        if (win_cnt == '0) state_d = S_DONE;
      end
      S_DONE: begin
        // start doubles as acknowledge + restart.
        if (start_i) begin
          state_d = S_ARM;
          accept  = 1'b1;
        end else if (ack_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      gate_sel_q <= 2'd0;
      arm_cnt    <= '0;
      win_cnt    <= '0;
      edge_cnt   <= '0;
      ovf_acc    <= 1'b0;
      count_o    <= '0;
      ovf_o      <= 1'b0;
    end else if (accept) begin
      gate_sel_q <= gate_sel_i;
      arm_cnt    <= ARM_W'(SYNC_STAGES);
      edge_cnt   <= '0;
      ovf_acc    <= 1'b0;
    end else if (state_q == S_ARM) begin
      // ARM spans SYNC_STAGES+1 cycles so pre-start synchronizer contents
      // can never produce a counted edge.
      if (arm_cnt != '0) begin
        arm_cnt <= arm_cnt - ARM_W'(1);
      end else begin
        win_cnt <= win_load;
      end
    end else if (state_q == S_COUNT) begin
      edge_cnt <= edge_nxt;
      ovf_acc  <= ovf_nxt;
      if (win_cnt != '0) begin
        win_cnt <= win_cnt - WIN_W'(1);
      end else begin
        // Last window cycle: an edge in this cycle is included.
        count_o <= edge_nxt;
        ovf_o   <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ro_freq_counter.sv
// tb/tb_ro_freq_counter.sv - scoreboard bench for ro_freq_counter
module tb_ro_freq_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ro_in;
  logic        start_i;
  logic [1:0]  gate_sel_i;
  logic        ack_i;
  logic        busy_o, done_o, ovf_o;
  logic [15:0] count_o;
  logic        busy8, done8, ovf8;
  logic [7:0]  count8;

  always #5 clk = ~clk;

  ro_freq_counter dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .ro_in(ro_in), .start_i(start_i),
    .gate_sel_i(gate_sel_i), .ack_i(ack_i), .busy_o(busy_o), .done_o(done_o),
    .count_o(count_o), .ovf_o(ovf_o)
  );

  ro_freq_counter #(.CNT_W(8)) dut8 (
    .wb_clk_i(clk), .wb_rst_i(rst), .ro_in(ro_in), .start_i(start_i),
    .gate_sel_i(gate_sel_i), .ack_i(ack_i), .busy_o(busy8), .done_o(done8),
    .count_o(count8), .ovf_o(ovf8)
  );

  typedef struct {
    int     c16;
    bit     o16;
    int     c8;
    bit     o8;
    int     lat;
    longint t0;
  } exp_t;

  exp_t   sb_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  longint cyc     = 0;
  bit     mon_en  = 1'b0;

  int ro_period = 2;
  int ro_ph     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint expv);
    n_tests++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  // Clock-aligned oscillator: high for period/2 cycles, low for the rest.
  initial begin
    ro_in = 1'b0;
    forever begin
      @(negedge clk);
      ro_ph++;
      if (ro_period > 0) ro_in = ((ro_ph % ro_period) < (ro_period / 2));
      else               ro_in = 1'b0;
    end
  end

  // Monitor: on every done rise pop the next expected result.
  initial begin
    bit   prev_done = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("busy_done_exclusive", longint'(busy_o & done_o), 0);
        if (done_o && !prev_done) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb_q.pop_front();
            chk("count16", count_o, e.c16);
            chk("ovf16", ovf_o, e.o16);
            chk("count8", count8, e.c8);
            chk("ovf8", ovf8, e.o8);
            chk("done8", done8, 1);
            chk("latency", cyc - e.t0, e.lat);
          end
        end
      end
      prev_done = done_o;
    end
  end

  task automatic pulse_start(input logic [1:0] sel);
    gate_sel_i = sel;
    start_i    = 1'b1;
    @(negedge clk);
    start_i    = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] sel, input int c16, input bit o16,
                          input int c8, input bit o8);
    exp_t e;
    e.c16 = c16; e.o16 = o16; e.c8 = c8; e.o8 = o8;
    e.lat = (256 << (2 * int'(sel))) + 4;
    e.t0  = cyc;
    sb_q.push_back(e);
    pulse_start(sel);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", done_o, 1);
  endtask

  task automatic do_ack();
    ack_i = 1'b1;
    @(negedge clk);
    ack_i = 1'b0;
    chk("ack_done_drop", done_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_i = 1'b0; ack_i = 1'b0; gate_sel_i = 2'd0;
    ro_period = 2;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_ovf", ovf_o, 0);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Basic count: period 8, W=256 -> 32 edges, done 260 cycles after start.
    ro_period = 8;
    do_start(2'd0, 32, 0, 32, 0);
    wait_done(400);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_count", count_o, 32);
      chk("hold_done", done_o, 1);
    end
    do_ack();
    chk("post_ack_count", count_o, 32);

    // Window scaling.
    do_start(2'd2, 512, 0, 255, 1);
    wait_done(5000);
    do_ack();
    ro_period = 0;
    do_start(2'd1, 0, 0, 0, 0);
    wait_done(1200);
    do_ack();

    // Saturation on the 8-bit instance: 256 edges then 64 edges.
    ro_period = 4;
    do_start(2'd1, 256, 0, 255, 1);
    wait_done(1200);
    do_ack();
    do_start(2'd0, 64, 0, 64, 0);
    wait_done(400);
    do_ack();

    // start while busy and gate_sel change mid-COUNT are both ignored.
    ro_period = 8;
    do_start(2'd0, 32, 0, 32, 0);
    repeat (100) @(negedge clk);
    pulse_start(2'd3);
    wait_done(400);
    // start in DONE restarts immediately.
    do_start(2'd0, 32, 0, 32, 0);
    chk("restart_busy", busy_o, 1);
    chk("restart_done", done_o, 0);
    wait_done(400);
    do_ack();

    // Reset 100 cycles into COUNT aborts with no retained result.
    pulse_start(2'd0);
    repeat (103) @(negedge clk);
    chk("pre_rst_busy", busy_o, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_done", done_o, 0);
    chk("midrst_count", count_o, 0);
    chk("midrst_ovf", ovf_o, 0);
    do_start(2'd0, 32, 0, 32, 0);
    wait_done(400);
    do_ack();

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ro_freq_counter.md
Name: ro_freq_counter

Overview:
Gated edge counter that measures the frequency of one ring-oscillator mux output (io_out[15] path) in the user project area. It sits directly downstream of the mux16x1 selection stage. The oscillator signal is asynchronous to wb_clk_i. The block synchronizes it, counts its rising edges over a programmable window of wb_clk_i cycles, and holds the result with a done/ack handshake for firmware or LA readout.

Parameters:
CNT_W, 16, width of edge-count result
GATE_LOG2, 8, log2 of shortest gate window in wb_clk_i cycles
SYNC_STAGES, 2, flops in ro_in synchronizer (minimum 2)

Ports:
wb_clk_i  input  1  system clock; the only clock in the block
wb_rst_i  input  1  synchronous, active-high reset
ro_in  input  1  ring-oscillator output from the mux; asynchronous
start_i  input  1  single-cycle request to begin a measurement
gate_sel_i  input  2  window select; sampled on an accepted start
ack_i  input  1  consumer acknowledge of a held result
busy_o  output  1  high while in ARM or COUNT
done_o  output  1  high while a result is held (DONE state)
count_o  output  CNT_W  edge count of the last measurement
ovf_o  output  1  count saturated during the last measurement

Behaviour:
- Reset:
  - One clock, synchronous, active-high reset on wb_rst_i.
  - Reset forces IDLE; busy_o=0, done_o=0, count_o=0, ovf_o=0; synchronizer and edge-detect flops cleared.
  - Reset mid-measurement aborts the measurement; no partial result is retained.
- Window:
  - W = 2^(GATE_LOG2 + 2*gate_sel_reg): 256, 1024, 4096, 16384 cycles at defaults.
  - gate_sel_i is latched only when a start is accepted; later changes have no effect on the running measurement.
- Synchronizer and edge detect:
  - ro_in passes through SYNC_STAGES flops plus one history flop.
  - A rise pulse is generated on a 0->1 transition of the synchronized signal.
  - Maximum countable rate is one edge every 2 cycles; faster inputs alias (documented limitation).
- FSM states: IDLE, ARM, COUNT, DONE.
  - IDLE: start_i=1 -> ARM; latch gate_sel; clear edge counter and ovf accumulator. count_o/ovf_o keep their previous values.
  - ARM: lasts exactly SYNC_STAGES+1 cycles to flush stale synchronizer state; rise pulses are ignored. Then -> COUNT with window counter loaded to W-1.
  - COUNT: lasts exactly W cycles.
    - Each rise pulse increments the edge counter.
    - At 2^CNT_W-1 the counter holds (saturates) and a sticky ovf flag is set.
    - On the last cycle (window counter = 0) a rise pulse in that same cycle is still counted.
    - Then -> DONE; count_o/ovf_o load the final values on the DONE entry edge.
  - DONE: done_o=1.
    - ack_i=1 -> IDLE, done_o drops next cycle; count_o/ovf_o hold until the next DONE entry.
    - start_i=1 (with or without ack_i) -> ARM directly; this acts as ack + restart.
- start_i while busy_o=1 is ignored, with no effect on the window or count. ack_i outside DONE is ignored.
- Latency: a start accepted in cycle 0 puts busy_o high from cycle 1. At defaults done_o rises in cycle W+SYNC_STAGES+2 (W+4).
- busy_o and done_o are never high together. Outputs are registered, with no combinational path from inputs to outputs.
- Arithmetic: window counter width is GATE_LOG2+7 bits (sized for sel=3), with no wrap. Edge counter is unsigned CNT_W and saturating, never wrapping.

Test Plan:
- Reset check: assert wb_rst_i 2 cycles with ro_in toggling -> busy_o=0, done_o=0, count_o=0, ovf_o=0.
- Basic count: ro_in clock-aligned with period 8 cycles, sel=0, pulse start_i -> done_o rises exactly 260 cycles after start; count_o=32, ovf_o=0. Hold 10 cycles without ack: values stable. Pulse ack_i -> done_o=0 next cycle, count_o stays 32.
- Window scaling: same ro_in, sel=2 -> count_o=512. ro_in held constant 0, sel=1 -> count_o=0.
- Saturation: CNT_W=8, ro_in period 4 cycles, sel=1 (W=1024, 256 edges) -> count_o=255, ovf_o=1. Next run at sel=0 (64 edges) -> count_o=64, ovf_o=0.
- Handshake edges:
  - start_i pulsed mid-COUNT -> ignored; done_o timing unchanged.
  - start_i in DONE -> busy_o=1 next cycle, done_o=0.
  - gate_sel_i changed during COUNT -> window length unchanged.
- Reset mid-operation: wb_rst_i asserted 100 cycles into COUNT -> IDLE next cycle, count_o=0. A fresh start then gives the normal result of 32 for the basic-count stimulus.
